// File: rtl/rib_pkg.sv
// Shared types and constants for the rib_hub single-master bus interconnect.
// Holds the FSM state encoding, the error read-data pattern and the wait-counter width helper.
package rib_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_ERR
   } ribState_e;

   localparam logic [31:0] RIB_ERR_DATA = 32'hDEAD_BEEF;

   // Width able to hold 0..timeout inclusive; never narrower than one bit.
   function automatic int unsigned cntWidth(input int unsigned timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/rib_decode.sv
// Combinational address decoder: one-hot window hit (lowest index wins) plus a miss flag.
module rib_decode #(
   parameter int unsigned          NSLV     = 4,
   parameter int unsigned          AW       = 32,
   parameter logic [NSLV*AW-1:0]   SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0},
   parameter logic [NSLV*AW-1:0]   SLV_MASK = {4{32'hF000_0000}}
) (
   input  logic [AW-1:0]   addr,
   output logic [NSLV-1:0] hit,
   output logic            miss
);

   logic found;

   always_comb begin
      hit   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (!found && ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
            hit[i] = 1'b1;
            found  = 1'b1;
         end
      end
      miss = ~found;
   end

endmodule

// File: rtl/rib_hub.sv
// Single-master req/ready interconnect fanning one core bus out to NSLV slave windows.
// Optional wait-state timeout to an error response is enabled by defining RIB_TIMEOUT_EN.
module rib_hub
   import rib_pkg::*;
#(
   parameter int unsigned          NSLV     = 4,
   parameter int unsigned          AW       = 32,
   parameter int unsigned          DW       = 32,
   parameter logic [NSLV*AW-1:0]   SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0},
   parameter logic [NSLV*AW-1:0]   SLV_MASK = {4{32'hF000_0000}},
   parameter int unsigned          TIMEOUT  = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m_req,
   input  logic                 m_we,
   input  logic [AW-1:0]        m_addr,
   input  logic [DW-1:0]        m_wdata,
   input  logic [DW/8-1:0]      m_wstrb,
   output logic                 m_ready,
   output logic [DW-1:0]        m_rdata,
   output logic                 m_err,
   output logic [NSLV-1:0]      s_req,
   output logic                 s_we,
   output logic [AW-1:0]        s_addr,
   output logic [DW-1:0]        s_wdata,
   output logic [DW/8-1:0]      s_wstrb,
   input  logic [NSLV-1:0]      s_ready,
   input  logic [NSLV*DW-1:0]   s_rdata
);

   localparam logic [DW-1:0] ERR_DATA = DW'(RIB_ERR_DATA);

   if (NSLV < 1 || TIMEOUT < 1) begin : gCfgCheck
      $error("rib_hub: NSLV and TIMEOUT must both be at least 1");
   end

   ribState_e       state;
   logic [NSLV-1:0] decHit;
   logic            decMiss;
   logic            selReady;
   logic [DW-1:0]   selRdata;

`ifdef RIB_TIMEOUT_EN
   localparam int unsigned CW = cntWidth(TIMEOUT);
   logic [CW-1:0] waitCnt;
`endif

   rib_decode #(
      .NSLV     (NSLV),
      .AW       (AW),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) uDecode (
      .addr (m_addr),
      .hit  (decHit),
      .miss (decMiss)
   );

   // s_req is one-hot while waiting, so it doubles as the return-path select.
   always_comb begin
      selRdata = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (s_req[i]) begin
            selRdata = selRdata | s_rdata[i*DW +: DW];
         end
      end
      selReady = |(s_ready & s_req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         s_req   <= '0;
         m_ready <= 1'b0;
         m_err   <= 1'b0;
         m_rdata <= '0;
         s_we    <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_wstrb <= '0;
`ifdef RIB_TIMEOUT_EN
         waitCnt <= '0;
`endif
      end else begin
         m_ready <= 1'b0;
         m_err   <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (m_req) begin
                  s_we    <= m_we;
                  s_addr  <= m_addr;
                  s_wdata <= m_wdata;
                  s_wstrb <= m_we ? m_wstrb : '0;
                  if (decMiss) begin
                     state   <= ST_ERR;
                     m_ready <= 1'b1;
                     m_err   <= 1'b1;
                     m_rdata <= ERR_DATA;
                  end else begin
                     state <= ST_WAIT;
                     s_req <= decHit;
`ifdef RIB_TIMEOUT_EN
                     waitCnt <= '0;
`endif
                  end
               end
            end
            ST_WAIT: begin
               if (selReady) begin
                  state   <= ST_RESP;
                  s_req   <= '0;
                  m_ready <= 1'b1;
                  m_rdata <= s_we ? '0 : selRdata;
               end
`ifdef RIB_TIMEOUT_EN
               // Last permitted wait cycle: a ready here still wins over the timeout.
               else if (waitCnt == CW'(TIMEOUT - 1)) begin
                  state   <= ST_ERR;
                  s_req   <= '0;
                  m_ready <= 1'b1;
                  m_err   <= 1'b1;
                  m_rdata <= ERR_DATA;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
`endif
            end
            ST_RESP: state <= ST_IDLE;
            ST_ERR:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
